// File: rtl/memory_access_stage_if.sv
// rtl/memory_access_stage_if.sv - EX-side op, register-file, data-memory and write-back bundle for the MA stage
interface memory_access_stage_if #(
  parameter int DATA_W = 16
);
  logic              in_valid;
  logic              in_ready;
  logic [2:0]        in_op;
  logic [DATA_W-1:0] in_addr;
  logic [DATA_W-1:0] in_wdata;
  logic [2:0]        in_dest;
  logic [DATA_W-1:0] in_alu_res;
  logic [7:0]        in_mask;
  logic [2:0]        rf_rd_addr;
  logic [DATA_W-1:0] rf_rd_data;
  logic              mem_req;
  logic              mem_we;
  logic [DATA_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ack;
  logic              wb_valid;
  logic [2:0]        wb_dest;
  logic [DATA_W-1:0] wb_data;
  logic              err;

  modport slave (
    input  in_valid, in_op, in_addr, in_wdata, in_dest, in_alu_res, in_mask,
    input  rf_rd_data, mem_rdata, mem_ack,
    output in_ready, rf_rd_addr, mem_req, mem_we, mem_addr, mem_wdata,
    output wb_valid, wb_dest, wb_data, err
  );

  modport master (
    output in_valid, in_op, in_addr, in_wdata, in_dest, in_alu_res, in_mask,
    output rf_rd_data, mem_rdata, mem_ack,
    input  in_ready, rf_rd_addr, mem_req, mem_we, mem_addr, mem_wdata,
    input  wb_valid, wb_dest, wb_data, err
  );
endinterface

// File: rtl/memory_access_stage.sv
// rtl/memory_access_stage.sv - IITB RISC memory-access stage: PASS, LW/SW and LM/SM over a req/ack data memory
// Reset input is active-high despite its name; it clears all state asynchronously.
module memory_access_stage #(
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 255
) (
  input logic                  clk,
  input logic                  resetn,
  memory_access_stage_if.slave bus
);

  localparam int CNT_W = $clog2(TIMEOUT + 2);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  localparam logic [2:0] OP_LW = 3'd1;
  localparam logic [2:0] OP_SW = 3'd2;
  localparam logic [2:0] OP_LM = 3'd3;
  localparam logic [2:0] OP_SM = 3'd4;

  typedef enum logic [1:0] {IDLE, SCAN, ACCESS} state_t;

  state_t            state_q, state_d;
  logic [2:0]        op_q, op_d;
  logic [2:0]        dest_q, dest_d;
  logic [7:0]        mask_q, mask_d;
  logic [DATA_W-1:0] base_q, base_d;
  logic [DATA_W-1:0] beat_cnt_q, beat_cnt_d;
  logic [2:0]        beat_q, beat_d;
  logic [CNT_W-1:0]  tmo_q, tmo_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [DATA_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              wb_valid_q, wb_valid_d;
  logic [2:0]        wb_dest_q, wb_dest_d;
  logic [DATA_W-1:0] wb_data_q, wb_data_d;
  logic              err_q, err_d;

  logic [2:0] low_idx;
  logic       ack;
  logic       tmo_hit;
  logic       multi_op;

  always_comb begin
    low_idx = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (mask_q[i]) low_idx = 3'(i);
    end
  end

  // An ack is only meaningful while a request is outstanding.
  assign ack      = bus.mem_ack && mem_req_q;
  assign tmo_hit  = (TIMEOUT != 0) && (tmo_q == TMO_LAST);
  assign multi_op = (op_q == OP_LM) || (op_q == OP_SM);

  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          case (bus.in_op)
            OP_LW, OP_SW: state_d = ACCESS;
            OP_LM, OP_SM: state_d = SCAN;
            default:      state_d = IDLE;
          endcase
        end
      end
      SCAN:    state_d = (mask_q == 8'd0) ? IDLE : ACCESS;
      ACCESS: begin
        if (ack)          state_d = multi_op ? SCAN : IDLE;
        else if (tmo_hit) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    op_d        = op_q;
    dest_d      = dest_q;
    mask_d      = mask_q;
    base_d      = base_q;
    beat_cnt_d  = beat_cnt_q;
    beat_d      = beat_q;
    tmo_d       = tmo_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    wb_valid_d  = 1'b0;
    wb_dest_d   = wb_dest_q;
    wb_data_d   = wb_data_q;
    err_d       = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          case (bus.in_op)
            OP_LW, OP_SW: begin
              op_d       = bus.in_op;
              dest_d     = bus.in_dest;
              mem_req_d  = 1'b1;
              mem_we_d   = (bus.in_op == OP_SW);
              mem_addr_d = bus.in_addr;
              tmo_d      = '0;
              if (bus.in_op == OP_SW) mem_wdata_d = bus.in_wdata;
            end
            OP_LM, OP_SM: begin
              op_d       = bus.in_op;
              mask_d     = bus.in_mask;
              base_d     = bus.in_addr;
              beat_cnt_d = '0;
            end
            default: begin
              wb_valid_d = 1'b1;
              wb_dest_d  = bus.in_dest;
              wb_data_d  = bus.in_alu_res;
            end
          endcase
        end
      end
      SCAN: begin
        if (mask_q != 8'd0) begin
          beat_d     = low_idx;
          mask_d     = mask_q & ~(8'd1 << low_idx);
          mem_req_d  = 1'b1;
          mem_we_d   = (op_q == OP_SM);
          mem_addr_d = base_q + beat_cnt_q;
          beat_cnt_d = beat_cnt_q + DATA_W'(1);
          tmo_d      = '0;
          if (op_q == OP_SM) mem_wdata_d = bus.rf_rd_data;
        end
      end
      ACCESS: begin
        if (ack) begin
          mem_req_d = 1'b0;
          if (op_q == OP_LW || op_q == OP_LM) begin
            wb_valid_d = 1'b1;
            wb_dest_d  = (op_q == OP_LW) ? dest_q : beat_q;
            wb_data_d  = bus.mem_rdata;
          end
        end else if (tmo_hit) begin
          // Abort the whole transfer, including any beats still in the mask.
          mem_req_d = 1'b0;
          err_d     = 1'b1;
          mask_d    = 8'd0;
        end else begin
          tmo_d = tmo_q + CNT_W'(1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      op_q        <= 3'd0;
      dest_q      <= 3'd0;
      mask_q      <= 8'd0;
      base_q      <= '0;
      beat_cnt_q  <= '0;
      beat_q      <= 3'd0;
      tmo_q       <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      wb_valid_q  <= 1'b0;
      wb_dest_q   <= 3'd0;
      wb_data_q   <= '0;
      err_q       <= 1'b0;
    end else begin
      op_q        <= op_d;
      dest_q      <= dest_d;
      mask_q      <= mask_d;
      base_q      <= base_d;
      beat_cnt_q  <= beat_cnt_d;
      beat_q      <= beat_d;
      tmo_q       <= tmo_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      wb_valid_q  <= wb_valid_d;
      wb_dest_q   <= wb_dest_d;
      wb_data_q   <= wb_data_d;
      err_q       <= err_d;
    end
  end

  // The register file is read combinationally, so SCAN presents the beat index in the same cycle.
  always_comb begin
    bus.in_ready   = (state_q == IDLE);
    bus.rf_rd_addr = (state_q == SCAN) ? low_idx : beat_q;
  end

  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.wb_valid  = wb_valid_q;
  assign bus.wb_dest   = wb_dest_q;
  assign bus.wb_data   = wb_data_q;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_memory_access_stage.sv
// tb/tb_memory_access_stage.sv - directed self-checking bench for memory_access_stage
module tb_memory_access_stage;

  logic clk;
  logic resetn;
  int   checks;
  int   passes;
  logic [15:0] rf_model [8];

  memory_access_stage_if #(.DATA_W(16)) bus ();

  memory_access_stage #(.DATA_W(16), .TIMEOUT(4)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb bus.rf_rd_data = rf_model[bus.rf_rd_addr];

  task automatic test_reset();
    #3;
    checks++; if (bus.in_ready !== 1'b1) $display("FAIL reset_in_ready got %b want 1", bus.in_ready); else passes++;
    checks++; if (bus.mem_req !== 1'b0) $display("FAIL reset_mem_req got %b want 0", bus.mem_req); else passes++;
    checks++; if (bus.mem_we !== 1'b0) $display("FAIL reset_mem_we got %b want 0", bus.mem_we); else passes++;
    checks++; if (bus.wb_valid !== 1'b0) $display("FAIL reset_wb_valid got %b want 0", bus.wb_valid); else passes++;
    checks++; if (bus.err !== 1'b0) $display("FAIL reset_err got %b want 0", bus.err); else passes++;
    checks++; if (bus.mem_addr !== 16'h0000) $display("FAIL reset_mem_addr got %h want 0000", bus.mem_addr); else passes++;
    checks++; if (bus.mem_wdata !== 16'h0000) $display("FAIL reset_mem_wdata got %h want 0000", bus.mem_wdata); else passes++;
    checks++; if (bus.wb_data !== 16'h0000) $display("FAIL reset_wb_data got %h want 0000", bus.wb_data); else passes++;
    checks++; if (bus.wb_dest !== 3'd0) $display("FAIL reset_wb_dest got %0d want 0", bus.wb_dest); else passes++;
    checks++; if (bus.rf_rd_addr !== 3'd0) $display("FAIL reset_rf_rd_addr got %0d want 0", bus.rf_rd_addr); else passes++;
    @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    checks++; if (bus.in_ready !== 1'b1) $display("FAIL post_reset_in_ready got %b want 1", bus.in_ready); else passes++;
  endtask

  task automatic test_stray_ack();
    bus.mem_ack = 1'b1;
    bus.mem_rdata = 16'hDEAD;
    @(negedge clk);
    bus.mem_ack = 1'b0;
    checks++; if (bus.wb_valid !== 1'b0) $display("FAIL stray_ack_wb got %b want 0", bus.wb_valid); else passes++;
    checks++; if (bus.in_ready !== 1'b1) $display("FAIL stray_ack_ready got %b want 1", bus.in_ready); else passes++;
  endtask

  task automatic test_pass();
    logic [15:0] data [3];
    logic [2:0]  ops [3];
    data[0] = 16'h1234; data[1] = 16'h2345; data[2] = 16'h3456;
    ops[0] = 3'd0; ops[1] = 3'd0; ops[2] = 3'd7;
    for (int k = 0; k < 3; k++) begin
      bus.in_valid = 1'b1;
      bus.in_op = ops[k];
      bus.in_dest = 3'(5 + k);
      bus.in_alu_res = data[k];
      @(negedge clk);
      checks++; if (bus.wb_valid !== 1'b1) $display("FAIL pass_wb_valid[%0d] got %b want 1", k, bus.wb_valid); else passes++;
      checks++; if (bus.wb_dest !== 3'(5 + k)) $display("FAIL pass_wb_dest[%0d] got %0d want %0d", k, bus.wb_dest, 5 + k); else passes++;
      checks++; if (bus.wb_data !== data[k]) $display("FAIL pass_wb_data[%0d] got %h want %h", k, bus.wb_data, data[k]); else passes++;
      checks++; if (bus.in_ready !== 1'b1) $display("FAIL pass_in_ready[%0d] got %b want 1", k, bus.in_ready); else passes++;
    end
    bus.in_valid = 1'b0;
    @(negedge clk);
    checks++; if (bus.wb_valid !== 1'b0) $display("FAIL pass_wb_idle got %b want 0", bus.wb_valid); else passes++;
  endtask

  task automatic test_lw();
    bus.in_valid = 1'b1; bus.in_op = 3'd1; bus.in_addr = 16'h0040; bus.in_dest = 3'd3;
    @(negedge clk);
    bus.in_valid = 1'b0;
    checks++; if (bus.in_ready !== 1'b0) $display("FAIL lw_busy got %b want 0", bus.in_ready); else passes++;
    for (int c = 0; c < 3; c++) begin
      checks++; if (bus.mem_req !== 1'b1) $display("FAIL lw_req[%0d] got %b want 1", c, bus.mem_req); else passes++;
      checks++; if (bus.mem_addr !== 16'h0040) $display("FAIL lw_addr[%0d] got %h want 0040", c, bus.mem_addr); else passes++;
      checks++; if (bus.mem_we !== 1'b0) $display("FAIL lw_we[%0d] got %b want 0", c, bus.mem_we); else passes++;
      if (c == 2) begin
        bus.mem_ack = 1'b1;
        bus.mem_rdata = 16'hBEEF;
      end
      @(negedge clk);
    end
    bus.mem_ack = 1'b0;
    checks++; if (bus.mem_req !== 1'b0) $display("FAIL lw_req_drop got %b want 0", bus.mem_req); else passes++;
    checks++; if (bus.wb_valid !== 1'b1) $display("FAIL lw_wb_valid got %b want 1", bus.wb_valid); else passes++;
    checks++; if (bus.wb_dest !== 3'd3) $display("FAIL lw_wb_dest got %0d want 3", bus.wb_dest); else passes++;
    checks++; if (bus.wb_data !== 16'hBEEF) $display("FAIL lw_wb_data got %h want beef", bus.wb_data); else passes++;
    checks++; if (bus.in_ready !== 1'b1) $display("FAIL lw_ready got %b want 1", bus.in_ready); else passes++;
    @(negedge clk);
    checks++; if (bus.wb_valid !== 1'b0) $display("FAIL lw_wb_pulse got %b want 0", bus.wb_valid); else passes++;
  endtask

  task automatic test_lm();
    logic [2:0] dests [3];
    dests[0] = 3'd1; dests[1] = 3'd5; dests[2] = 3'd7;
    bus.in_valid = 1'b1; bus.in_op = 3'd3; bus.in_addr = 16'h0100; bus.in_mask = 8'b1010_0010;
    @(negedge clk);
    bus.in_valid = 1'b0;
    checks++; if (bus.in_ready !== 1'b0) $display("FAIL lm_busy got %b want 0", bus.in_ready); else passes++;
    for (int b = 0; b < 3; b++) begin
      @(negedge clk);
      checks++; if (bus.mem_req !== 1'b1) $display("FAIL lm_req[%0d] got %b want 1", b, bus.mem_req); else passes++;
      checks++; if (bus.mem_addr !== 16'(16'h0100 + b)) $display("FAIL lm_addr[%0d] got %h want %h", b, bus.mem_addr, 16'(16'h0100 + b)); else passes++;
      checks++; if (bus.mem_we !== 1'b0) $display("FAIL lm_we[%0d] got %b want 0", b, bus.mem_we); else passes++;
      bus.mem_ack = 1'b1;
      bus.mem_rdata = 16'(16'hA000 + dests[b]);
      @(negedge clk);
      bus.mem_ack = 1'b0;
      checks++; if (bus.wb_valid !== 1'b1) $display("FAIL lm_wb_valid[%0d] got %b want 1", b, bus.wb_valid); else passes++;
      checks++; if (bus.wb_dest !== dests[b]) $display("FAIL lm_wb_dest[%0d] got %0d want %0d", b, bus.wb_dest, dests[b]); else passes++;
      checks++; if (bus.wb_data !== 16'(16'hA000 + dests[b])) $display("FAIL lm_wb_data[%0d] got %h want %h", b, bus.wb_data, 16'(16'hA000 + dests[b])); else passes++;
      checks++; if (bus.mem_req !== 1'b0) $display("FAIL lm_req_drop[%0d] got %b want 0", b, bus.mem_req); else passes++;
    end
    @(negedge clk);
    checks++; if (bus.in_ready !== 1'b1) $display("FAIL lm_done_ready got %b want 1", bus.in_ready); else passes++;
    checks++; if (bus.wb_valid !== 1'b0) $display("FAIL lm_done_wb got %b want 0", bus.wb_valid); else passes++;
  endtask

  task automatic test_sm_zero_mask();
    bus.in_valid = 1'b1; bus.in_op = 3'd4; bus.in_addr = 16'h0500; bus.in_mask = 8'd0;
    @(negedge clk);
    bus.in_valid = 1'b0;
    checks++; if (bus.in_ready !== 1'b0) $display("FAIL sm0_scan_ready got %b want 0", bus.in_ready); else passes++;
    checks++; if (bus.mem_req !== 1'b0) $display("FAIL sm0_scan_req got %b want 0", bus.mem_req); else passes++;
    @(negedge clk);
    checks++; if (bus.in_ready !== 1'b1) $display("FAIL sm0_idle_ready got %b want 1", bus.in_ready); else passes++;
    checks++; if (bus.mem_req !== 1'b0) $display("FAIL sm0_idle_req got %b want 0", bus.mem_req); else passes++;
  endtask

  task automatic test_sm_wrap();
    logic [15:0] addrs [2];
    logic [15:0] wdat [2];
    addrs[0] = 16'hFFFF; addrs[1] = 16'h0000;
    wdat[0] = 16'hAAAA; wdat[1] = 16'h5555;
    rf_model[0] = 16'hAAAA;
    rf_model[1] = 16'h5555;
    bus.in_valid = 1'b1; bus.in_op = 3'd4; bus.in_addr = 16'hFFFF; bus.in_mask = 8'b0000_0011;
    @(negedge clk);
    bus.in_valid = 1'b0;
    checks++; if (bus.rf_rd_addr !== 3'd0) $display("FAIL sm_rf_addr got %0d want 0", bus.rf_rd_addr); else passes++;
    for (int b = 0; b < 2; b++) begin
      @(negedge clk);
      checks++; if (bus.mem_req !== 1'b1) $display("FAIL sm_req[%0d] got %b want 1", b, bus.mem_req); else passes++;
      checks++; if (bus.mem_we !== 1'b1) $display("FAIL sm_we[%0d] got %b want 1", b, bus.mem_we); else passes++;
      checks++; if (bus.mem_addr !== addrs[b]) $display("FAIL sm_addr[%0d] got %h want %h", b, bus.mem_addr, addrs[b]); else passes++;
      checks++; if (bus.mem_wdata !== wdat[b]) $display("FAIL sm_wdata[%0d] got %h want %h", b, bus.mem_wdata, wdat[b]); else passes++;
      bus.mem_ack = 1'b1;
      @(negedge clk);
      bus.mem_ack = 1'b0;
      checks++; if (bus.wb_valid !== 1'b0) $display("FAIL sm_wb[%0d] got %b want 0", b, bus.wb_valid); else passes++;
    end
    @(negedge clk);
    checks++; if (bus.in_ready !== 1'b1) $display("FAIL sm_done_ready got %b want 1", bus.in_ready); else passes++;
  endtask

  task automatic test_timeout();
    int  cnt;
    bit  dropped;
    cnt = 0;
    dropped = 1'b0;
    bus.in_valid = 1'b1; bus.in_op = 3'd2; bus.in_addr = 16'h0200; bus.in_wdata = 16'h1357;
    @(negedge clk);
    bus.in_valid = 1'b0;
    checks++; if (bus.mem_wdata !== 16'h1357) $display("FAIL sw_wdata got %h want 1357", bus.mem_wdata); else passes++;
    checks++; if (bus.mem_we !== 1'b1) $display("FAIL sw_we got %b want 1", bus.mem_we); else passes++;
    for (int c = 0; c < 12 && !dropped; c++) begin
      if (bus.mem_req === 1'b1) begin
        cnt++;
        @(negedge clk);
      end else begin
        dropped = 1'b1;
      end
    end
    checks++; if (cnt != 4) $display("FAIL tmo_req_cycles got %0d want 4", cnt); else passes++;
    checks++; if (bus.err !== 1'b1) $display("FAIL tmo_err got %b want 1", bus.err); else passes++;
    checks++; if (bus.in_ready !== 1'b1) $display("FAIL tmo_ready got %b want 1", bus.in_ready); else passes++;
    checks++; if (bus.wb_valid !== 1'b0) $display("FAIL tmo_wb got %b want 0", bus.wb_valid); else passes++;
    @(negedge clk);
    checks++; if (bus.err !== 1'b0) $display("FAIL tmo_err_pulse got %b want 0", bus.err); else passes++;
    checks++; if (bus.mem_req !== 1'b0) $display("FAIL tmo_req_after got %b want 0", bus.mem_req); else passes++;
  endtask

  task automatic test_ack_at_limit();
    int held;
    held = 0;
    bus.in_valid = 1'b1; bus.in_op = 3'd1; bus.in_addr = 16'h0050; bus.in_dest = 3'd2;
    @(negedge clk);
    bus.in_valid = 1'b0;
    for (int c = 0; c < 4; c++) begin
      if (bus.mem_req === 1'b1) held++;
      if (c == 3) begin
        bus.mem_ack = 1'b1;
        bus.mem_rdata = 16'h4321;
      end
      @(negedge clk);
    end
    bus.mem_ack = 1'b0;
    checks++; if (held != 4) $display("FAIL lim_req_cycles got %0d want 4", held); else passes++;
    checks++; if (bus.err !== 1'b0) $display("FAIL lim_err got %b want 0", bus.err); else passes++;
    checks++; if (bus.wb_valid !== 1'b1) $display("FAIL lim_wb_valid got %b want 1", bus.wb_valid); else passes++;
    checks++; if (bus.wb_data !== 16'h4321) $display("FAIL lim_wb_data got %h want 4321", bus.wb_data); else passes++;
    checks++; if (bus.wb_dest !== 3'd2) $display("FAIL lim_wb_dest got %0d want 2", bus.wb_dest); else passes++;
  endtask

  task automatic test_reset_mid();
    bus.in_valid = 1'b1; bus.in_op = 3'd3; bus.in_addr = 16'h0300; bus.in_mask = 8'b0000_0110;
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(negedge clk);
    bus.mem_ack = 1'b1;
    bus.mem_rdata = 16'h0B0B;
    @(negedge clk);
    bus.mem_ack = 1'b0;
    checks++; if (bus.wb_dest !== 3'd1) $display("FAIL mid_first_dest got %0d want 1", bus.wb_dest); else passes++;
    @(negedge clk);
    checks++; if (bus.mem_addr !== 16'h0301) $display("FAIL mid_second_addr got %h want 0301", bus.mem_addr); else passes++;
    bus.mem_ack = 1'b1;
    bus.mem_rdata = 16'h0C0C;
    #2 resetn = 1'b1;
    #1;
    checks++; if (bus.mem_req !== 1'b0) $display("FAIL mid_async_req got %b want 0", bus.mem_req); else passes++;
    checks++; if (bus.wb_valid !== 1'b0) $display("FAIL mid_async_wb got %b want 0", bus.wb_valid); else passes++;
    checks++; if (bus.in_ready !== 1'b1) $display("FAIL mid_async_ready got %b want 1", bus.in_ready); else passes++;
    @(negedge clk);
    resetn = 1'b0;
    bus.mem_ack = 1'b0;
    @(negedge clk);
    checks++; if (bus.wb_valid !== 1'b0) $display("FAIL mid_after_wb got %b want 0", bus.wb_valid); else passes++;
    checks++; if (bus.err !== 1'b0) $display("FAIL mid_after_err got %b want 0", bus.err); else passes++;
    bus.in_valid = 1'b1; bus.in_op = 3'd0; bus.in_dest = 3'd2; bus.in_alu_res = 16'h0F0F;
    @(negedge clk);
    bus.in_valid = 1'b0;
    checks++; if (bus.wb_valid !== 1'b1) $display("FAIL mid_pass_valid got %b want 1", bus.wb_valid); else passes++;
    checks++; if (bus.wb_data !== 16'h0F0F) $display("FAIL mid_pass_data got %h want 0f0f", bus.wb_data); else passes++;
    checks++; if (bus.wb_dest !== 3'd2) $display("FAIL mid_pass_dest got %0d want 2", bus.wb_dest); else passes++;
  endtask

  initial begin
    checks = 0;
    passes = 0;
    for (int r = 0; r < 8; r++) rf_model[r] = 16'h0000;
    resetn = 1'b1;
    bus.in_valid = 1'b0; bus.in_op = 3'd0; bus.in_addr = 16'h0000; bus.in_wdata = 16'h0000;
    bus.in_dest = 3'd0; bus.in_alu_res = 16'h0000; bus.in_mask = 8'd0;
    bus.mem_rdata = 16'h0000; bus.mem_ack = 1'b0;
    test_reset();
    test_stray_ack();
    test_pass();
    test_lw();
    test_lm();
    test_sm_zero_mask();
    test_sm_wrap();
    test_timeout();
    test_ack_at_limit();
    test_reset_mid();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/memory_access_stage.md
Name: memory_access_stage

Overview:
- Pipeline stage between the EX-to-MA register and the MA-to-WB register in the IITB RISC processor.
- Performs data-memory loads and stores, including LM/SM multi-register transfers, over a req/ack data-memory interface.
- Passes ALU results through to write-back unchanged.
- Stalls upstream through a ready handshake while a memory transaction is in flight.

Parameters:
- DATA_W, 16, data and address width.
- TIMEOUT, 255, maximum cycles to wait for mem_ack before aborting; 0 disables the timeout.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- resetn  in  1  reset, asynchronous and active-high (asserted = 1).
- in_valid  in  1  EX has an operation for MA.
- in_ready  out  1  MA can accept an operation.
- in_op  in  3  0=PASS, 1=LW, 2=SW, 3=LM, 4=SM; 5-7 are treated as PASS.
- in_addr  in  DATA_W  effective address (base for LM/SM).
- in_wdata  in  DATA_W  store data for SW.
- in_dest  in  3  destination register for PASS/LW.
- in_alu_res  in  DATA_W  ALU result for PASS.
- in_mask  in  8  register mask for LM/SM; bit i selects Ri.
- rf_rd_addr  out  3  register-file read address used during SM.
- rf_rd_data  in  DATA_W  combinational register-file read data.
- mem_req  out  1  data-memory request.
- mem_we  out  1  1 = write.
- mem_addr  out  DATA_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  read data, valid with mem_ack.
- mem_ack  in  1  memory completion.
- wb_valid  out  1  one-cycle write-back pulse.
- wb_dest  out  3  write-back register.
- wb_data  out  DATA_W  write-back data.
- err  out  1  one-cycle pulse on timeout abort.

Behaviour:
- Reset (asynchronous):
  - State goes to IDLE.
  - in_ready=1.
  - mem_req, mem_we, wb_valid, err = 0.
  - mem_addr, mem_wdata, wb_data, wb_dest, rf_rd_addr = 0.
  - Timeout counter and latched mask cleared.
  - Reset mid-transaction drops mem_req immediately and discards the operation; no wb_valid or err is produced for it.
- State machine: IDLE, SCAN, ACCESS.
- IDLE:
  - in_ready=1; an operation is accepted on a cycle with in_valid=1.
  - PASS: next cycle wb_valid=1, wb_dest=in_dest, wb_data=in_alu_res; stay IDLE. Back-to-back PASS gives one result per cycle.
  - LW/SW: go to ACCESS; mem_req=1 from the next cycle with mem_addr=in_addr and mem_we=(op==SW); mem_wdata=in_wdata for SW.
  - LM/SM: latch in_mask, in_addr and the op; go to SCAN.
- in_ready=0 in SCAN and ACCESS.
- SCAN:
  - Latched mask zero: return to IDLE with no memory access and no wb pulse. This is the end of an LM/SM.
  - Otherwise take the lowest set bit i as the beat register and clear that bit.
  - Set rf_rd_addr=i. For SM, register mem_wdata=rf_rd_data in the same cycle.
  - Issue mem_req with mem_addr = base + beat count (the k-th beat uses base+k, mod 2^DATA_W wrap) and mem_we=(op==SM).
  - Go to ACCESS. Each beat costs one SCAN cycle.
- ACCESS:
  - mem_req, mem_we, mem_addr and mem_wdata stay stable until mem_ack is sampled 1.
  - On ack, mem_req drops in the next cycle.
  - LW: wb_valid=1 next cycle with wb_data=mem_rdata and wb_dest=in_dest; go to IDLE.
  - SW: no wb pulse; go to IDLE.
  - LM: wb_valid=1 next cycle with wb_dest=i and wb_data=mem_rdata; go to SCAN.
  - SM: no wb pulse; go to SCAN.
- mem_ack sampled while mem_req=0 is ignored.
- Timeout:
  - The counter resets at each request issue and increments each ACCESS cycle without ack.
  - If TIMEOUT≠0 and the counter reaches TIMEOUT: drop mem_req, pulse err for one cycle, abandon the remaining beats, go to IDLE. No wb pulse for the aborted beat.
  - An ack in the same cycle the limit is reached takes priority over the timeout.
- Latency:
  - PASS: 1 cycle.
  - LW: 1 cycle plus memory latency plus 1 cycle.
  - LM with n set bits: n×(SCAN + access + 1).

Test Plan:
1. PASS, in_alu_res=0x1234, in_dest=5, three back-to-back PASS ops -> wb_valid pulses on 3 consecutive cycles, first with dest 5 and data 0x1234; in_ready stays 1 throughout.
2. LW at addr 0x0040, memory acks after 3 cycles with rdata 0xBEEF -> mem_req held 3 cycles with addr 0x0040 and we=0; then wb_valid with dest=in_dest and data 0xBEEF; in_ready=0 until return to IDLE.
3. LM base 0x0100, mask 0b10100010, ack in 1 cycle each -> reads 0x0100, 0x0101, 0x0102; wb dests 1, 5, 7 in that order; SM with mask 0 -> no mem_req and back in IDLE after one SCAN.
4. SM base 0xFFFF, mask 0b00000011, R0=0xAAAA, R1=0x5555 -> writes (0xFFFF, 0xAAAA) then (0x0000, 0x5555); no wb_valid.
5. TIMEOUT=4, SW with mem_ack never asserted -> mem_req high 4 cycles, then drops; err pulses once; state returns to IDLE with in_ready=1.
6. resetn asserted mid-LM on the second beat -> mem_req and wb_valid go to 0 asynchronously; after release, a new PASS completes normally.
